// File: rtl/datapath_seq_pkg.sv
// datapath_seq shared types: op kinds, conditions,
// ALU function codes and FSM states.
package datapath_seq_pkg;

  typedef enum logic [2:0] {
    ALU_RR  = 3'd0,
    ALU_RI  = 3'd1,
    LOADIMM = 3'd2,
    MOVE    = 3'd3,
    LOAD    = 3'd4,
    STORE   = 3'd5
  } op_kind_e;

  typedef enum logic [1:0] {
    ALWAYS   = 2'd0,
    IF_TRUE  = 2'd1,
    IF_FALSE = 2'd2
  } op_cond_e;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLL    = 4'd6;
  localparam logic [3:0] ALU_SRL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_PASS_B = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MEM  = 1'b1
  } state_e;

endpackage

// File: rtl/datapath_seq_regfile.sv
// dp_regfile: register array, two async read ports,
// one write port that overrides the IP increment.
module dp_regfile
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IP_REG   = 10,
  parameter int OUT_REG  = 12,
  parameter int RIDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              incr_ip,
  input  logic [RIDX_W-1:0] raddr_a,
  input  logic [RIDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] out_reg
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign out_reg = regs_q[OUT_REG];

  // Next register state: IP step first, explicit write last
  always_comb begin
    regs_d = regs_q;
    if (incr_ip)
      regs_d[IP_REG] = regs_q[IP_REG] + DATA_W'(DATA_W / 8);
    if (we)
      regs_d[waddr] = wdata;
  end

  // Register array with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: regfile + ALU + req/ack memory FSM.
// Optional flags register: DATAPATH_SEQ_FLAGS_EN.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IP_REG   = 10,
  parameter int OUT_REG  = 12,
  parameter int TIMEOUT  = 15,
  parameter int RIDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_kind,
  input  logic [1:0]        op_cond,
  input  logic [RIDX_W-1:0] op_src,
  input  logic [RIDX_W-1:0] op_dst,
  input  logic [3:0]        op_alu,
  input  logic [DATA_W-1:0] op_imm,
  input  logic              op_byte,
  input  logic              op_incr_ip,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err,
`ifdef DATAPATH_SEQ_FLAGS_EN
  output logic [2:0]        flags,
`endif
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] out_reg
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  op_kind_e kind;
  op_cond_e cond;
  state_e   state_q, state_d;

  logic              mem_we_q, mem_we_d;
  logic              mem_byte_q, mem_byte_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [RIDX_W-1:0] dst_q, dst_d;
  logic              incr_q, incr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              rf_we, rf_incr;
  logic [RIDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] alu_b, alu_res;
  logic              accept, is_mem, is_alu;
  logic              cond_z, cond_ok;

`ifdef DATAPATH_SEQ_FLAGS_EN
  logic [DATA_W:0]   sum, dif;
  logic              alu_c;
  logic [2:0]        flags_q, flags_d;
  assign flags = flags_q;
`else
  logic [DATA_W-1:0] sum, dif;
`endif

  assign kind     = op_kind_e'(op_kind);
  assign cond     = op_cond_e'(op_cond);
  assign op_ready = (state_q == S_IDLE);
  assign accept   = op_valid && op_ready;
  assign is_mem   = (kind == LOAD) || (kind == STORE);
  assign is_alu   = (kind == ALU_RR) || (kind == ALU_RI);

  assign mem_req   = (state_q == S_MEM);
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

  dp_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .IP_REG  (IP_REG),
    .OUT_REG (OUT_REG),
    .RIDX_W  (RIDX_W)
  ) u_rf (
    .clock  (clock),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .incr_ip(rf_incr),
    .raddr_a(op_src),
    .raddr_b(op_dst),
    .rdata_a(reg_a),
    .rdata_b(reg_b),
    .out_reg(out_reg)
  );

  // ALU: operand B from register or immediate
  always_comb begin
    alu_b = (kind == ALU_RR) ? reg_b : op_imm;
`ifdef DATAPATH_SEQ_FLAGS_EN
    sum   = {1'b0, reg_a} + {1'b0, alu_b};
    dif   = {1'b0, reg_a} - {1'b0, alu_b};
    alu_c = (op_alu == ALU_ADD) ? sum[DATA_W] :
            (op_alu == ALU_SUB) ? dif[DATA_W] : 1'b0;
`else
    sum   = reg_a + alu_b;
    dif   = reg_a - alu_b;
`endif
    case (op_alu)
      ALU_ADD:    alu_res = sum[DATA_W-1:0];
      ALU_SUB:    alu_res = dif[DATA_W-1:0];
      ALU_AND:    alu_res = reg_a & alu_b;
      ALU_OR:     alu_res = reg_a | alu_b;
      ALU_XOR:    alu_res = reg_a ^ alu_b;
      ALU_SLT:    alu_res = DATA_W'($signed(reg_a) < $signed(alu_b));
      ALU_SLL:    alu_res = reg_a << alu_b[SH_W-1:0];
      ALU_SRL:    alu_res = reg_a >> alu_b[SH_W-1:0];
      ALU_SRA:    alu_res = $signed(reg_a) >>> alu_b[SH_W-1:0];
      ALU_PASS_B: alu_res = alu_b;
      default:    alu_res = '0;
    endcase
  end

  // Condition evaluation at acceptance
  always_comb begin
`ifdef DATAPATH_SEQ_FLAGS_EN
    cond_z = flags_q[0];
`else
    cond_z = (reg_a == '0);
`endif
    case (cond)
      ALWAYS:   cond_ok = 1'b1;
      IF_TRUE:  cond_ok = !cond_z;
      IF_FALSE: cond_ok = cond_z;
      default:  cond_ok = 1'b0;
    endcase
  end

  // FSM next state, memory latches and regfile write
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_byte_d  = mem_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dst_d       = dst_q;
    incr_d      = incr_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rf_we       = 1'b0;
    rf_incr     = 1'b0;
    rf_waddr    = op_dst;
    rf_wdata    = alu_res;
`ifdef DATAPATH_SEQ_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mem && cond_ok) begin
            state_d     = S_MEM;
            mem_we_d    = (kind == STORE);
            mem_byte_d  = op_byte;
            mem_addr_d  = reg_a + op_imm;
            mem_wdata_d = op_byte ?
              {{(DATA_W-8){1'b0}}, reg_b[7:0]} : reg_b;
            dst_d       = op_dst;
            incr_d      = op_incr_ip;
            cnt_d       = '0;
          end else begin
            done_d  = 1'b1;
            rf_incr = op_incr_ip;
            rf_we   = cond_ok && !is_mem &&
                      (kind inside {ALU_RR, ALU_RI, LOADIMM, MOVE});
            if (kind == LOADIMM)   rf_wdata = op_imm;
            else if (kind == MOVE) rf_wdata = reg_a;
`ifdef DATAPATH_SEQ_FLAGS_EN
            if (is_alu)
              flags_d = {alu_res[DATA_W-1], alu_c, alu_res == '0};
`endif
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          rf_incr  = incr_q;
          rf_we    = !mem_we_q;
          rf_waddr = dst_q;
          rf_wdata = mem_byte_q ?
            {{(DATA_W-8){1'b0}}, mem_rdata[7:0]} : mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rf_incr = incr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and memory-port registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dst_q       <= '0;
      incr_q      <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef DATAPATH_SEQ_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dst_q       <= dst_d;
      incr_q      <= incr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef DATAPATH_SEQ_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed vectors for datapath_seq.
// Expected values are hand-computed constants.
module tb_datapath_seq;
  import datapath_seq_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          op_valid, op_ready;
  logic [2:0]    op_kind;
  logic [1:0]    op_cond;
  logic [RW-1:0] op_src, op_dst;
  logic [3:0]    op_alu;
  logic [DW-1:0] op_imm;
  logic          op_byte, op_incr_ip;
  logic          mem_req, mem_we, mem_byte;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          done, err;
  logic [DW-1:0] reg_a, reg_b, out_reg;
`ifdef DATAPATH_SEQ_FLAGS_EN
  logic [2:0]    flags;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  datapath_seq dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_kind   (op_kind),
    .op_cond   (op_cond),
    .op_src    (op_src),
    .op_dst    (op_dst),
    .op_alu    (op_alu),
    .op_imm    (op_imm),
    .op_byte   (op_byte),
    .op_incr_ip(op_incr_ip),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_byte  (mem_byte),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .done      (done),
    .err       (err),
`ifdef DATAPATH_SEQ_FLAGS_EN
    .flags     (flags),
`endif
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .out_reg   (out_reg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input op_kind_e k, input op_cond_e c,
                       input int s, input int d,
                       input logic [3:0] a, input logic [DW-1:0] imm,
                       input logic by, input logic inc);
    op_kind    = k;
    op_cond    = c;
    op_src     = RW'(s);
    op_dst     = RW'(d);
    op_alu     = a;
    op_imm     = imm;
    op_byte    = by;
    op_incr_ip = inc;
    op_valid   = 1'b1;
    tick();
    op_valid   = 1'b0;
  endtask

  task automatic peek(input int s, input int d);
    op_src = RW'(s);
    op_dst = RW'(d);
    #1;
  endtask

  task automatic mem_phase(input int ack_at, input logic [DW-1:0] rd,
                           output int nreq, output int cyc,
                           output logic gd, output logic ge);
    nreq = 0;
    cyc  = 0;
    gd   = 1'b0;
    ge   = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_req) nreq++;
      if (c == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      tick();
      mem_ack = 1'b0;
      if (done) begin
        gd  = 1'b1;
        ge  = err;
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   nreq, cyc;
    logic gd, ge;
    reset = 1'b1;
    op_valid = 1'b0; op_kind = '0; op_cond = '0;
    op_src = '0; op_dst = '0; op_alu = '0; op_imm = '0;
    op_byte = 1'b0; op_incr_ip = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", op_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_out", out_reg, 0);
`ifdef DATAPATH_SEQ_FLAGS_EN
    chk("rst_flags", flags, 0);
`endif

    // LOADIMM with IP increment
    issue(LOADIMM, ALWAYS, 0, 3, 0, 32'h1234, 0, 1);
    chk("li_done", done, 1);
    peek(10, 3);
    chk("li_r3", reg_b, 32'h1234);
    chk("li_ip", reg_a, 4);
    tick();
    chk("li_done_pulse", done, 0);

    // back-to-back register ops
    issue(LOADIMM, ALWAYS, 0, 1, 0, 5, 0, 0);
    issue(LOADIMM, ALWAYS, 0, 2, 0, 7, 0, 0);
    chk("b2b_done", done, 1);
    issue(ALU_RR, ALWAYS, 1, 2, ALU_SUB, 0, 0, 0);
    chk("sub_done", done, 1);
    peek(1, 2);
    chk("sub_r2", reg_b, 32'hFFFF_FFFE);
`ifdef DATAPATH_SEQ_FLAGS_EN
    chk("sub_flags", flags, 3'b110);
`endif

    // immediate ALU ops
    issue(LOADIMM, ALWAYS, 0, 14, 0, 32'h99, 0, 0);
    issue(ALU_RI, ALWAYS, 1, 5, ALU_ADD, 32'h10, 0, 0);
    issue(ALU_RI, ALWAYS, 2, 6, ALU_SLT, 0, 0, 0);
    issue(ALU_RI, ALWAYS, 2, 7, ALU_SRA, 1, 0, 0);
    issue(ALU_RI, ALWAYS, 2, 8, ALU_SRL, 28, 0, 0);
    issue(ALU_RI, ALWAYS, 5, 13, ALU_XOR, 32'hFF, 0, 0);
    issue(ALU_RI, ALWAYS, 5, 14, 4'd12, 1, 0, 0);
    issue(ALU_RI, ALWAYS, 1, 15, ALU_SLL, 33, 0, 0);
    issue(LOADIMM, ALWAYS, 0, 12, 0, 32'hCAFE, 0, 0);
    peek(5, 6);
    chk("add_r5", reg_a, 32'h15);
    chk("slt_r6", reg_b, 1);
    peek(7, 8);
    chk("sra_r7", reg_a, 32'hFFFF_FFFF);
    chk("srl_r8", reg_b, 32'hF);
    peek(13, 14);
    chk("xor_r13", reg_a, 32'hEA);
    chk("bad_code_r14", reg_b, 0);
    peek(15, 0);
    chk("sll_wrap_r15", reg_a, 32'hA);
    chk("out_reg", out_reg, 32'hCAFE);

    // word STORE, ack in third MEM cycle
    issue(LOADIMM, ALWAYS, 0, 4, 0, 32'hA5A5_A5A5, 0, 0);
    issue(STORE, ALWAYS, 0, 4, 0, 32'h10, 0, 0);
    chk("st_done0", done, 0);
    chk("st_req", mem_req, 1);
    chk("st_ready", op_ready, 0);
    chk("st_we", mem_we, 1);
    chk("st_byte", mem_byte, 0);
    chk("st_addr", mem_addr, 32'h10);
    chk("st_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_phase(3, 0, nreq, cyc, gd, ge);
    chk("st_nreq", nreq, 3);
    chk("st_cyc", cyc, 3);
    chk("st_gdone", gd, 1);
    chk("st_err", ge, 0);
    chk("st_req_off", mem_req, 0);

    // byte LOAD with immediate ack
    issue(LOAD, ALWAYS, 0, 11, 0, 32'h20, 1, 0);
    chk("ldb_addr", mem_addr, 32'h20);
    chk("ldb_we", mem_we, 0);
    chk("ldb_byte", mem_byte, 1);
    mem_phase(1, 32'hDEAD_BEEF, nreq, cyc, gd, ge);
    chk("ldb_cyc", cyc, 1);
    chk("ldb_gdone", gd, 1);
    peek(0, 11);
    chk("ldb_r11", reg_b, 32'hEF);

    // byte STORE
    issue(STORE, ALWAYS, 1, 4, 0, 3, 1, 0);
    chk("stb_addr", mem_addr, 32'h8);
    chk("stb_wdata", mem_wdata, 32'hA5);
    chk("stb_byte", mem_byte, 1);
    mem_phase(2, 0, nreq, cyc, gd, ge);
    chk("stb_cyc", cyc, 2);

    // LOAD timeout
    issue(LOADIMM, ALWAYS, 0, 9, 0, 32'h77, 0, 0);
    issue(LOAD, ALWAYS, 0, 9, 0, 32'h40, 0, 1);
    mem_phase(0, 32'h1111_1111, nreq, cyc, gd, ge);
    chk("to_nreq", nreq, 15);
    chk("to_cyc", cyc, 15);
    chk("to_gdone", gd, 1);
    chk("to_err", ge, 1);
    peek(10, 9);
    chk("to_r9", reg_b, 32'h77);
    chk("to_ip", reg_a, 8);
    tick();
    chk("to_err_pulse", err, 0);

    // conditional ops
    issue(MOVE, IF_TRUE, 0, 3, 0, 0, 0, 0);
    chk("ift_no_done", done, 1);
    peek(0, 3);
    chk("ift_no_r3", reg_b, 32'h1234);
    issue(MOVE, IF_TRUE, 1, 13, 0, 0, 0, 0);
    peek(1, 13);
    chk("ift_yes_r13", reg_b, 5);
    issue(MOVE, IF_FALSE, 1, 12, 0, 0, 0, 0);
    chk("iff_no_out", out_reg, 32'hCAFE);
    issue(STORE, IF_TRUE, 0, 4, 0, 0, 0, 0);
    chk("sup_st_req", mem_req, 0);
    chk("sup_st_done", done, 1);
    chk("sup_st_ready", op_ready, 1);

    // stray ack in IDLE
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_done", done, 0);
    chk("idle_ack_req", mem_req, 0);

    // reset while in MEM
    issue(LOAD, ALWAYS, 0, 3, 0, 32'h30, 0, 0);
    chk("rm_req1", mem_req, 1);
    tick();
    chk("rm_req2", mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_req_off", mem_req, 0);
    chk("rm_done", done, 0);
    tick();
    chk("rm_done2", done, 0);
    chk("rm_out", out_reg, 0);
    chk("rm_ready", op_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Parametrised, sequenced successor to the CPU datapath. It holds a NUM_REGS x DATA_W register file and a combinational ALU, and drives an external request/acknowledge memory port through a small state machine with a timeout. Operations arrive one at a time on a valid/ready handshake from the controller. Each one retires with a one-cycle `done` pulse.

## Interface
Parameters:
- DATA_W, 32, datapath and register width (multiple of 8, at least 16)
- NUM_REGS, 16, register count; RIDX_W = clog2(NUM_REGS)
- IP_REG, 10, index of the instruction-pointer register
- OUT_REG, 12, index of the output register, mirrored on `out_reg`
- TIMEOUT, 15, maximum MEM-state cycles before abort (at least 1)

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation present
- op_ready  out  1  high only in IDLE
- op_kind  in  3  ALU_RR, ALU_RI, LOADIMM, MOVE, LOAD, STORE
- op_cond  in  2  ALWAYS, IF_TRUE, IF_FALSE
- op_src, op_dst  in  RIDX_W  source and destination register indices
- op_alu  in  4  ALU function code
- op_imm  in  DATA_W  immediate
- op_byte  in  1  byte-wide memory access
- op_incr_ip  in  1  advance IP on retire
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  store
- mem_byte  out  1  byte access
- mem_addr, mem_wdata  out  DATA_W  address and store data
- mem_ack  in  1  completion, one cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- done  out  1  one-cycle retire pulse
- err  out  1  one-cycle pulse with `done` on memory timeout
- reg_a, reg_b  out  DATA_W  combinational reads of reg[op_src] and reg[op_dst]
- out_reg  out  DATA_W  reg[OUT_REG]

## Operation
- An operation is accepted when op_valid && op_ready.
- Operand A is reg[op_src]. For ALU_RR, operand B is reg[op_dst]; for ALU_RI, it is op_imm.
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 PASS_B. Codes 10–15 produce 0. Shift amount is B[clog2(DATA_W)-1:0]. Results are truncated to DATA_W.
- ALU_RR and ALU_RI write the ALU result to reg[op_dst]. LOADIMM writes op_imm. MOVE writes reg[op_src].
- LOAD and STORE use mem_addr = reg[op_src] + op_imm, truncated. STORE drives mem_wdata = reg[op_dst].
- A byte load zero-extends mem_rdata[7:0]. A byte store drives mem_wdata with the low byte in [7:0] and zeros elsewhere, with mem_byte set.
- Condition test: the write or store is performed only if the condition holds. ALWAYS always holds. IF_TRUE holds when cond_z == 0. IF_FALSE holds when cond_z == 1.
- A suppressed LOAD or STORE never enters MEM and retires like a register op.
- When op_incr_ip is set, reg[IP_REG] += DATA_W/8 at the retire edge. If the operation also writes IP_REG in that edge, the operation's write wins.
- FSM states: IDLE and MEM.
  - IDLE, accepting a register op: the write happens at the accept edge and the FSM stays in IDLE.
  - IDLE, accepting LOAD/STORE: mem_addr, mem_wdata, mem_we, mem_byte and the destination are latched, and the FSM goes to MEM.
  - MEM: mem_req is high. On mem_ack, a LOAD writes the destination register and the FSM returns to IDLE.
  - MEM timeout: if TIMEOUT cycles pass without ack, the FSM returns to IDLE with no register write and err is raised. IP still increments.
- mem_ack is ignored in IDLE.

## Timing
- Reset values: all registers 0, state IDLE, mem_req/mem_we/mem_byte 0, mem_addr/mem_wdata 0, done 0, err 0, flags 0.
- Register op: `done` is high in the cycle after acceptance. Back-to-back acceptance is possible every cycle.
- Memory op: mem_req rises in the cycle after acceptance. `done` is high in the cycle after the ack edge. Minimum accept-to-done is 2 cycles.
- Memory outputs are registered and stable for the whole MEM state.
- A write in cycle N is visible on reg_a/reg_b in cycle N+1. There is no bypass.
- Reset in MEM drops mem_req in the next cycle. No write occurs and no `done` is produced.

## Configuration
- DATAPATH_SEQ_FLAGS_EN defined: a flags register {N, C, Z} is updated on every ALU_RR/ALU_RI retire. C is the carry out of ADD or the borrow of SUB, and is 0 for other codes. cond_z = Z. A `flags` output (3 bits) is added.
- DATAPATH_SEQ_FLAGS_EN undefined: no flags register and no `flags` port. cond_z = (reg[op_src] == 0), evaluated combinationally at acceptance.

## Structure
- Package datapath_seq_pkg holds the op_kind enum, the op_cond enum, the ALU code constants and the state enum.
- Sub-module dp_regfile holds the register array, the two combinational read ports, a single write port with IP-increment port priority, and the synchronous clear.

## Test plan
- Reset, then LOADIMM r3 = 0x1234 with incr_ip -> `done` after 1 cycle; reg_b (dst=3) = 0x1234; r10 = 4.
- r1 = 5, r2 = 7, then ALU_RR SUB src 1 dst 2 -> r2 = 0xFFFFFFFE; with the macro defined, flags N=1, C=1, Z=0.
- STORE r4 = 0xA5A5A5A5 to r0 + 0x10, ack after 3 cycles -> mem_req high 3 cycles, mem_wdata = 0xA5A5A5A5, `done` 1 cycle after ack.
- Byte LOAD with mem_rdata = 0xDEADBEEF -> dst = 0x000000EF.
- LOAD with no ack -> mem_req high for 15 cycles, then `done` and err pulse together; destination unchanged.
- IF_TRUE MOVE with condition false -> no write, `done` pulses. Reset asserted mid-MEM -> mem_req 0 next cycle, no `done`.
